// File: rtl/regfile_psr_pkg.sv
// Shared definitions for the ALU operand/result stage: datapath widths,
// PSR flag bit positions, ALU opcodes and the default per-opcode flag mask.
// Optional build macro used by regfile_psr: REGFILE_BYPASS_EN.
package regfile_psr_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;
  localparam int FLAG_W = 5;

  // PSR bit positions, {Z,C,F,N,L} = [4:0]
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_XOR   = 4'd2,
    OP_NOT   = 4'd3,
    OP_ADD   = 4'd4,
    OP_ADDU  = 4'd5,
    OP_ADDC  = 4'd6,
    OP_ADDCU = 4'd7,
    OP_SUB   = 4'd8,
    OP_SUBU  = 4'd9,
    OP_CMP   = 4'd10,
    OP_CMPU  = 4'd11,
    OP_LSH   = 4'd12,
    OP_LSHI  = 4'd13
  } alu_op_e;

  typedef logic [FLAG_W-1:0] flags_t;

  // Default flags_we the control stage builds per opcode. Logic ops only
  // touch Z/N; arithmetic and compares load everything; shifts load Z/N/C.
  function automatic flags_t flags_we_for(alu_op_e op);
    flags_t m;
    m = '0;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      OP_LSH, OP_LSHI: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
        m[FLAG_C] = 1'b1;
      end
      default: m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/regfile_psr_if.sv
// Bus between the control/ALU side (master) and the register file (slave).
interface regfile_psr_if;
  import regfile_psr_pkg::*;

  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [FLAG_W-1:0] flags_in;
  logic [FLAG_W-1:0] flags_we;
  logic [FLAG_W-1:0] psr;
  logic              cin;

  modport master (
    output ra_addr, rb_addr, wr_en, wr_addr, wr_data, flags_in, flags_we,
    input  ra_data, rb_data, psr, cin
  );

  modport slave (
    input  ra_addr, rb_addr, wr_en, wr_addr, wr_data, flags_in, flags_we,
    output ra_data, rb_data, psr, cin
  );
endinterface

// File: rtl/regfile_psr_psr_reg.sv
// Processor status register: per-bit masked load, async clear.
// cin is the carry bit straight off the register (never bypassed).
module psr_reg
  import regfile_psr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] flags_we,
  output logic [FLAG_W-1:0] psr,
  output logic              cin
);

  // Load only the bits whose mask is set; the rest hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) psr <= '0;
    else       psr <= (psr & ~flags_we) | (flags_in & flags_we);
  end

  assign cin = psr[FLAG_C];

endmodule

// File: rtl/regfile_psr.sv
// Operand/result stage around the 16-bit ALU: NREGS x DATA_W register file
// with two combinational read ports and one write port, plus the PSR.
// Build macro REGFILE_BYPASS_EN: when defined, a read of the register being
// written this cycle returns wr_data (write-through forwarding).
module regfile_psr
  import regfile_psr_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  regfile_psr_if.slave bus
);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             wr_sel;
  logic [DATA_W-1:0]            ra_arr, rb_arr;
  logic [DATA_W-1:0]            ra_q, rb_q;

  // One-hot write decode; an address past NREGS selects nothing and is dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NREGS; i++)
      wr_sel[i] = bus.wr_en && (bus.wr_addr == ADDR_W'(i));
  end

  // Per-register storage, each cleared asynchronously.
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset)          regs[g] <= '0;
      else if (wr_sel[g]) regs[g] <= bus.wr_data;
    end
  end

  // Read muxes; an unmatched (out-of-range) address reads 0.
  always_comb begin
    ra_arr = '0;
    rb_arr = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.ra_addr == ADDR_W'(i)) ra_arr = regs[i];
      if (bus.rb_addr == ADDR_W'(i)) rb_arr = regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_ok;
  assign wr_ok = |wr_sel;

  // Forward the in-flight write to a port reading the same register.
  always_comb begin
    ra_q = ra_arr;
    rb_q = rb_arr;
    if (wr_ok && (bus.ra_addr == bus.wr_addr)) ra_q = bus.wr_data;
    if (wr_ok && (bus.rb_addr == bus.wr_addr)) rb_q = bus.wr_data;
  end
`else
  // No forwarding: new data shows up the cycle after the write.
  always_comb begin
    ra_q = ra_arr;
    rb_q = rb_arr;
  end
`endif

  // Ports read 0 while reset is held, even with a write pending.
  assign bus.ra_data = reset ? '0 : ra_q;
  assign bus.rb_data = reset ? '0 : rb_q;

  psr_reg u_psr (
    .clk      (clk),
    .reset    (reset),
    .flags_in (bus.flags_in),
    .flags_we (bus.flags_we),
    .psr      (bus.psr),
    .cin      (bus.cin)
  );

endmodule

// File: tb/tb_regfile_psr.sv
// Directed bench for regfile_psr: reset, write/read, same-cycle read of the
// write target, masked PSR loads, combined writes, idle hold, async reset.
module tb_regfile_psr;
  import regfile_psr_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  regfile_psr_if bus ();

  regfile_psr dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    bus.ra_addr = a;
    bus.rb_addr = b;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset        = 1'b1;
    bus.ra_addr  = '0;
    bus.rb_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.flags_in = '0;
    bus.flags_we = '0;

    // Reset state
    #3;
    chk("rst_ra", 32'(bus.ra_data), 32'h0);
    chk("rst_rb", 32'(bus.rb_data), 32'h0);
    chk("rst_psr", 32'(bus.psr), 32'h0);
    chk("rst_cin", 32'(bus.cin), 32'h0);
    tick();
    reset = 1'b0;

    // Basic write then read next cycle
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3;  bus.wr_data = 16'h1234;
    tick();
    bus.wr_addr = 4'd15; bus.wr_data = 16'hFFFF;
    tick();
    bus.wr_en = 1'b0;
    rd(4'd3, 4'd15);
    chk("r3", 32'(bus.ra_data), 32'h1234);
    chk("r15", 32'(bus.rb_data), 32'hFFFF);
    rd(4'd4, 4'd4);
    chk("r4_zero", 32'(bus.ra_data), 32'h0);

    // Same-cycle read of the write target
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'h00AA;
    rd(4'd5, 4'd3);
`ifdef REGFILE_BYPASS_EN
    chk("r5_same_cycle", 32'(bus.ra_data), 32'h00AA);
`else
    chk("r5_same_cycle", 32'(bus.ra_data), 32'h0);
`endif
    chk("rb_unaffected", 32'(bus.rb_data), 32'h1234);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("r5_next", 32'(bus.ra_data), 32'h00AA);

    // Masked PSR loads; carry reaches cin the next cycle
    bus.flags_in = 5'b11111; bus.flags_we = 5'b10011;
    tick();
    bus.flags_we = '0;
    #1;
    chk("psr_10011", 32'(bus.psr), 32'h13);
    chk("cin_0", 32'(bus.cin), 32'h0);
    bus.flags_in = 5'b01000; bus.flags_we = 5'b01000;
    #1;
    chk("psr_no_bypass", 32'(bus.psr), 32'h13);
    tick();
    bus.flags_we = '0;
    #1;
    chk("psr_11011", 32'(bus.psr), 32'h1B);
    chk("cin_1", 32'(bus.cin), 32'h1);

    // Register write and full PSR load on the same edge
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h8000;
    bus.flags_in = 5'b00110; bus.flags_we = 5'b11111;
    tick();
    bus.wr_en = 1'b0; bus.flags_we = '0;
    rd(4'd7, 4'd5);
    chk("r7", 32'(bus.ra_data), 32'h8000);
    chk("psr_00110", 32'(bus.psr), 32'h06);
    chk("cin_cleared", 32'(bus.cin), 32'h0);

    // r0 is an ordinary register
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    rd(4'd0, 4'd7);
    chk("r0_writable", 32'(bus.ra_data), 32'hBEEF);

    // Idle with noise on the data inputs: nothing changes
    for (int i = 0; i < 10; i++) begin
      bus.wr_addr  = 4'($urandom_range(15));
      bus.wr_data  = 16'($urandom);
      bus.flags_in = 5'($urandom);
      tick();
    end
    rd(4'd3, 4'd15);
    chk("idle_r3", 32'(bus.ra_data), 32'h1234);
    chk("idle_r15", 32'(bus.rb_data), 32'hFFFF);
    rd(4'd5, 4'd7);
    chk("idle_r5", 32'(bus.ra_data), 32'h00AA);
    chk("idle_r7", 32'(bus.rb_data), 32'h8000);
    rd(4'd0, 4'd4);
    chk("idle_r0", 32'(bus.ra_data), 32'hBEEF);
    chk("idle_psr", 32'(bus.psr), 32'h06);

    // Async reset mid-run: everything clears before the next edge
    #10;
    reset = 1'b1;
    #1;
    chk("arst_psr", 32'(bus.psr), 32'h0);
    chk("arst_cin", 32'(bus.cin), 32'h0);
    for (int i = 0; i < NREGS; i++) begin
      rd(4'(i), 4'(NREGS - 1 - i));
      chk($sformatf("arst_ra%0d", i), 32'(bus.ra_data), 32'h0);
      chk($sformatf("arst_rb%0d", i), 32'(bus.rb_data), 32'h0);
    end

    // A write and flag load presented while reset is held are lost
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h5555;
    bus.flags_in = 5'b11111; bus.flags_we = 5'b11111;
    rd(4'd3, 4'd3);
    chk("rst_port_gated", 32'(bus.ra_data), 32'h0);
    tick();
    chk("rst_psr_held", 32'(bus.psr), 32'h0);

    // First edge with reset low takes the write
    reset = 1'b0;
    bus.flags_we = '0;
    bus.wr_addr = 4'd9; bus.wr_data = 16'h1357;
    tick();
    bus.wr_en = 1'b0;
    rd(4'd9, 4'd3);
    chk("first_wr_r9", 32'(bus.ra_data), 32'h1357);
    chk("lost_wr_r3", 32'(bus.rb_data), 32'h0);
    chk("psr_post_rst", 32'(bus.psr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
